// File: rtl/div_pkg.sv
// Shared constants and state encodings for the sequential divider.
// Signed support is selected by the DIV_SIGNED_EN macro.
package div_pkg;

  localparam int DIV_DATA_W = 32;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider.
// Purely combinational; the caller owns all state.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_DATA_W
) (
  input  logic [W-1:0] rem_i,
  input  logic         msb_i,
  input  logic [W-1:0] dsr_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0]   shl;
  logic [W-1:0] diff;

  // rem < divisor on entry, so the shifted value fits in W+1 bits
  // and any successful subtraction fits back into W bits.
  always_comb begin
    shl   = {rem_i, msb_i};
    diff  = shl[W-1:0] - dsr_i;
    q_o   = (shl >= {1'b0, dsr_i});
    rem_o = q_o ? diff : shl[W-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
// Define DIV_SIGNED_EN to enable DIV (signed) support.
module div_seq
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam logic [CNT_W-1:0] CNT_DONE =
    CNT_W'(DATA_W);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                rdy_q, rdy_d;

  logic [DATA_W-1:0] op1_abs;
  logic [DATA_W-1:0] op2_abs;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  logic [DATA_W-1:0] step_rem;
  logic              step_q;

`ifdef DIV_SIGNED_EN
  logic neg1_q, neg1_d;
  logic neg2_q, neg2_d;
  logic neg1_in;
  logic neg2_in;

  // Magnitudes on entry, sign restoration on exit.
  always_comb begin
    neg1_in = signed_div_i & opdata1_i[DATA_W-1];
    neg2_in = signed_div_i & opdata2_i[DATA_W-1];
    op1_abs = neg1_in ? (~opdata1_i + 1'b1)
                      : opdata1_i;
    op2_abs = neg2_in ? (~opdata2_i + 1'b1)
                      : opdata2_i;
    quo_fix = (neg1_q ^ neg2_q) ? (~dvd_q + 1'b1)
                                : dvd_q;
    rem_fix = neg1_q ? (~rem_q + 1'b1) : rem_q;
  end
`else
  logic unused_signed;

  assign unused_signed = signed_div_i;

  // Unsigned only: operands and results pass straight through.
  always_comb begin
    op1_abs = opdata1_i;
    op2_abs = opdata2_i;
    quo_fix = dvd_q;
    rem_fix = rem_q;
  end
`endif

  div_step #(
    .W (DATA_W)
  ) u_step (
    .rem_i (rem_q),
    .msb_i (dvd_q[DATA_W-1]),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Next-state and datapath updates; hold everything by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
`ifdef DIV_SIGNED_EN
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
`endif
    unique case (state_q)
      S_FREE: begin
        res_d = '0;
        rdy_d = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            dvd_d   = op1_abs;
            dsr_d   = op2_abs;
            cnt_d   = '0;
            rem_d   = '0;
`ifdef DIV_SIGNED_EN
            neg1_d  = neg1_in;
            neg2_d  = neg2_in;
`endif
          end
        end
      end
      S_BYZERO: begin
        state_d = S_END;
        res_d   = '0;
        rdy_d   = DIV_RESULT_READY;
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
          res_d   = '0;
          rdy_d   = DIV_RESULT_NOT_READY;
        end else if (cnt_q != CNT_DONE) begin
          rem_d = step_rem;
          dvd_d = {dvd_q[DATA_W-2:0], step_q};
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = S_END;
          res_d   = {rem_fix, quo_fix};
          rdy_d   = DIV_RESULT_READY;
        end
      end
      S_END: begin
        if (start_i == DIV_STOP) begin
          state_d = S_FREE;
          res_d   = '0;
          rdy_d   = DIV_RESULT_NOT_READY;
        end
      end
      default: begin
        state_d = S_FREE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FREE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      res_q   <= '0;
      rdy_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef DIV_SIGNED_EN
  // Operand signs captured at start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
    end else begin
      neg1_q <= neg1_d;
      neg2_q <= neg2_d;
    end
  end
`endif

  assign result_o = res_q;
  assign ready_o  = rdy_q;

endmodule
